// File: rtl/bcd_timer_pkg.sv
// Shared types and BCD helpers for the multi-field countdown timer.
// Fields are two packed BCD digits {tens, units}.
package bcd_timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SET     = 3'd1,
        ST_RUN     = 3'd2,
        ST_PAUSE   = 3'd3,
        ST_EXPIRED = 3'd4
    } state_t;

    // Saturate each digit to 9, then saturate the value to the field maximum.
    function automatic logic [7:0] bcd_clamp(input logic [7:0] value, input logic [7:0] max_val);
        logic [7:0] sat;
        sat[7:4] = (value[7:4] > 4'd9) ? 4'd9 : value[7:4];
        sat[3:0] = (value[3:0] > 4'd9) ? 4'd9 : value[3:0];
        return (sat > max_val) ? max_val : sat;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] value, input logic [7:0] max_val);
        logic [7:0] res;
        if (value == 8'h00) begin
            res = max_val;
        end else if (value[3:0] == 4'd0) begin
            res = {value[7:4] - 4'd1, 4'd9};
        end else begin
            res = {value[7:4], value[3:0] - 4'd1};
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_field_dec.sv
// One two-digit BCD field of the countdown chain: load, borrow-gated decrement,
// wrap from 00 to the field maximum, and borrow out when the field is at 00.
module bcd_field_dec
    import bcd_timer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    input  logic       i_dec_en,
    input  logic [7:0] i_max,
    input  logic       i_borrow_in,
    output logic       o_borrow_out,
    output logic       o_is_zero,
    output logic [7:0] o_value
);

    logic [7:0] r_value;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_value <= 8'h00;
        end else if (i_load) begin
            r_value <= i_load_val;
        end else if (i_dec_en && i_borrow_in) begin
            r_value <= bcd_dec(r_value, i_max);
        end
    end

    assign o_is_zero    = (r_value == 8'h00);
    assign o_borrow_out = i_borrow_in && o_is_zero;
    assign o_value      = r_value;

endmodule

// File: rtl/bcd_countdown_timer.sv
// N-field BCD countdown timer with set/run/pause/expired control and expiry flasher.
// Define AUTO_RELOAD_EN to reload the last completed entry on reaching zero instead of expiring.
module bcd_countdown_timer
    import bcd_timer_pkg::*;
#(
    parameter int         NUM_FIELDS = 2,
    parameter logic [7:0] LOW_MAX    = 8'h59,
    parameter logic [7:0] TOP_MAX    = 8'h99,
    parameter int         FLASH_DIV  = 25_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    set_p,
    input  logic                    start_stop_p,
    input  logic                    tick,
    input  logic [7:0]              sw,
    output logic [8*NUM_FIELDS-1:0] display_bcd,
    output logic [8*NUM_FIELDS-1:0] count_bcd,
    output logic [1:0]              set_idx,
    output logic                    running,
    output logic                    expired,
    output logic                    expired_p,
    output logic                    flash
);

    localparam int         CNT_W    = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [1:0] LAST_IDX = 2'(NUM_FIELDS - 1);

    state_t                r_state, w_state_nxt;
    logic [1:0]            r_set_idx, w_set_idx_nxt;
    logic                  r_expired_p, w_expire;
    logic                  r_flash;
    logic [CNT_W-1:0]      r_flash_cnt;
    logic                  w_dec_en, w_load_sw;
    logic                  w_count_zero, w_reaches_zero;
    logic [NUM_FIELDS-1:0] w_borrow, w_zero;
    logic [7:0]            w_field [NUM_FIELDS];
`ifdef AUTO_RELOAD_EN
    logic                  w_load_reload, w_store_reload;
`endif

    // The borrow out of the top field is high exactly when every field is 00.
    assign w_count_zero   = w_borrow[NUM_FIELDS-1];
    assign w_reaches_zero = (w_field[0] == 8'h01) && (&(w_zero | NUM_FIELDS'(1)));

    // NOTE: every signal written here gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_set_idx_nxt = r_set_idx;
        w_load_sw     = 1'b0;
        w_dec_en      = 1'b0;
        w_expire      = 1'b0;
`ifdef AUTO_RELOAD_EN
        w_load_reload  = 1'b0;
        w_store_reload = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (set_p) begin
                    w_state_nxt   = ST_SET;
                    w_set_idx_nxt = 2'd0;
                end else if (start_stop_p && !w_count_zero) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_SET: begin
                if (set_p) begin
                    w_load_sw = 1'b1;
                    if (r_set_idx == LAST_IDX) begin
                        w_state_nxt   = ST_IDLE;
                        w_set_idx_nxt = 2'd0;
`ifdef AUTO_RELOAD_EN
                        w_store_reload = 1'b1;
`endif
                    end else begin
                        w_set_idx_nxt = r_set_idx + 2'd1;
                    end
                end else if (start_stop_p) begin
                    w_state_nxt   = ST_IDLE;
                    w_set_idx_nxt = 2'd0;
                end
            end
            ST_RUN: begin
                if (start_stop_p) begin
                    w_state_nxt = ST_PAUSE;
                end else if (tick && !w_count_zero) begin
                    w_dec_en = 1'b1;
                    if (w_reaches_zero) begin
                        w_expire = 1'b1;
`ifdef AUTO_RELOAD_EN
                        w_load_reload = 1'b1;
`else
                        w_state_nxt = ST_EXPIRED;
`endif
                    end
                end
            end
            ST_PAUSE, ST_EXPIRED: begin
                if (set_p) begin
                    w_state_nxt   = ST_SET;
                    w_set_idx_nxt = 2'd0;
                end else if (start_stop_p) begin
                    w_state_nxt = (r_state == ST_PAUSE) ? ST_RUN : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_set_idx   <= 2'd0;
            r_expired_p <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_set_idx   <= w_set_idx_nxt;
            r_expired_p <= w_expire;
        end
    end

    // Flash divider only advances while staying in EXPIRED; any exit clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flash_cnt <= '0;
            r_flash     <= 1'b0;
        end else if (r_state == ST_EXPIRED && w_state_nxt == ST_EXPIRED) begin
            if (r_flash_cnt == CNT_W'(FLASH_DIV - 1)) begin
                r_flash_cnt <= '0;
                r_flash     <= ~r_flash;
            end else begin
                r_flash_cnt <= r_flash_cnt + 1'b1;
            end
        end else begin
            r_flash_cnt <= '0;
            r_flash     <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_field
        localparam logic [7:0] FIELD_MAX = (g == NUM_FIELDS - 1) ? TOP_MAX : LOW_MAX;

        logic [7:0] w_sw_val, w_load_val;
        logic       w_load, w_borrow_in;

        assign w_sw_val = bcd_clamp(sw, FIELD_MAX);

        if (g == 0) begin : g_lsb
            assign w_borrow_in = 1'b1;
        end else begin : g_chain
            assign w_borrow_in = w_borrow[g-1];
        end

`ifdef AUTO_RELOAD_EN
        logic [7:0] r_reload;

        // NOTE: the reload register is a plain flop per field, so it takes the async reset.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_reload <= 8'h00;
            end else if (w_store_reload) begin
                r_reload <= (g == NUM_FIELDS - 1) ? w_sw_val : w_field[g];
            end
        end

        assign w_load_val = w_load_reload ? r_reload : w_sw_val;
        assign w_load     = (w_load_sw && r_set_idx == 2'(g)) || w_load_reload;
`else
        assign w_load_val = w_sw_val;
        assign w_load     = w_load_sw && r_set_idx == 2'(g);
`endif

        bcd_field_dec u_field (
            .clk         (clk),
            .reset       (reset),
            .i_load      (w_load),
            .i_load_val  (w_load_val),
            .i_dec_en    (w_dec_en),
            .i_max       (FIELD_MAX),
            .i_borrow_in (w_borrow_in),
            .o_borrow_out(w_borrow[g]),
            .o_is_zero   (w_zero[g]),
            .o_value     (w_field[g])
        );

        assign count_bcd[8*g +: 8]   = w_field[g];
        assign display_bcd[8*g +: 8] = (r_state == ST_SET && r_set_idx == 2'(g)) ? sw : w_field[g];
    end

    assign set_idx   = r_set_idx;
    assign running   = (r_state == ST_RUN);
    assign expired   = (r_state == ST_EXPIRED);
    assign expired_p = r_expired_p;
    assign flash     = r_flash;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer: a seconds-based reference model predicts every
// cycle's outputs into a queue, and a monitor compares them against the DUT.
`timescale 1ns/1ps
module tb_bcd_countdown_timer;

    localparam int         NF        = 2;
    localparam logic [7:0] LOW_MAX   = 8'h59;
    localparam logic [7:0] TOP_MAX   = 8'h99;
    localparam int         FLASH_DIV = 4;
    localparam int         W         = 8 * NF;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         set_p = 1'b0;
    logic         start_stop_p = 1'b0;
    logic         tick = 1'b0;
    logic [7:0]   sw = 8'h00;
    logic [W-1:0] display_bcd, count_bcd;
    logic [1:0]   set_idx;
    logic         running, expired, expired_p, flash;

    bcd_countdown_timer #(
        .NUM_FIELDS(NF), .LOW_MAX(LOW_MAX), .TOP_MAX(TOP_MAX), .FLASH_DIV(FLASH_DIV)
    ) dut (
        .clk(clk), .reset(reset), .set_p(set_p), .start_stop_p(start_stop_p), .tick(tick),
        .sw(sw), .display_bcd(display_bcd), .count_bcd(count_bcd), .set_idx(set_idx),
        .running(running), .expired(expired), .expired_p(expired_p), .flash(flash)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (seconds arithmetic) ----------------
    typedef enum {M_IDLE, M_SET, M_RUN, M_PAUSE, M_EXPIRED} mode_t;
    typedef struct {
        logic [W-1:0] count;
        logic [1:0]   idx;
        bit in_set, run, exp, exp_p, fl;
    } exp_t;

    exp_t  sb[$];
    mode_t m_mode;
    int    m_f[NF];
    int    m_reload[NF];
    int    m_idx, m_k;
    bit    m_exp_p;

    function automatic int fmax(input int i);
        logic [7:0] b;
        b = (i == NF - 1) ? TOP_MAX : LOW_MAX;
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic int clamp_int(input logic [7:0] v, input int i);
        int t, u, val;
        t   = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
        u   = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
        val = t * 10 + u;
        return (val > fmax(i)) ? fmax(i) : val;
    endfunction

    function automatic int total();
        int t = 0, w = 1;
        for (int i = 0; i < NF; i++) begin
            t += m_f[i] * w;
            w *= fmax(i) + 1;
        end
        return t;
    endfunction

    function automatic void set_total(input int secs);
        int t = secs;
        for (int i = 0; i < NF - 1; i++) begin
            m_f[i] = t % (fmax(i) + 1);
            t      = t / (fmax(i) + 1);
        end
        m_f[NF-1] = t;
    endfunction

    function automatic logic [W-1:0] model_count();
        logic [W-1:0] c;
        for (int i = 0; i < NF; i++) c[8*i +: 8] = 8'(((m_f[i] / 10) << 4) | (m_f[i] % 10));
        return c;
    endfunction

    function automatic void model_reset();
        m_mode = M_IDLE; m_idx = 0; m_k = 0; m_exp_p = 0;
        for (int i = 0; i < NF; i++) begin m_f[i] = 0; m_reload[i] = 0; end
    endfunction

    function automatic void model_step(input bit sp, input bit ssp, input bit tk, input logic [7:0] v);
        mode_t prev = m_mode;
        int    t;
        m_exp_p = 0;
        case (m_mode)
            M_IDLE: if (sp) begin m_mode = M_SET; m_idx = 0; end
                    else if (ssp && total() != 0) m_mode = M_RUN;
            M_SET: begin
                if (sp) begin
                    m_f[m_idx] = clamp_int(v, m_idx);
                    if (m_idx == NF - 1) begin
                        m_reload = m_f; m_mode = M_IDLE; m_idx = 0;
                    end else m_idx++;
                end else if (ssp) begin m_mode = M_IDLE; m_idx = 0; end
            end
            M_RUN: begin
                if (ssp) m_mode = M_PAUSE;
                else if (tk && total() != 0) begin
                    t = total() - 1;
                    if (t == 0) begin
                        m_exp_p = 1;
`ifdef AUTO_RELOAD_EN
                        m_f = m_reload;
`else
                        set_total(0);
                        m_mode = M_EXPIRED;
`endif
                    end else set_total(t);
                end
            end
            M_PAUSE:   if (sp) begin m_mode = M_SET; m_idx = 0; end else if (ssp) m_mode = M_RUN;
            M_EXPIRED: if (sp) begin m_mode = M_SET; m_idx = 0; end else if (ssp) m_mode = M_IDLE;
            default:   m_mode = M_IDLE;
        endcase
        if (m_mode == M_EXPIRED && prev == M_EXPIRED) m_k++; else m_k = 0;
    endfunction

    // ---------------- driver ----------------
    task automatic step(input bit sp, input bit ssp, input bit tk, input logic [7:0] v);
        exp_t e;
        @(negedge clk);
        set_p = sp; start_stop_p = ssp; tick = tk; sw = v;
        model_step(sp, ssp, tk, v);
        e.count  = model_count();
        e.idx    = 2'(m_idx);
        e.in_set = (m_mode == M_SET);
        e.run    = (m_mode == M_RUN);
        e.exp    = (m_mode == M_EXPIRED);
        e.exp_p  = m_exp_p;
        e.fl     = (m_mode == M_EXPIRED) && (((m_k / FLASH_DIV) % 2) == 1);
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin step(1'b0, 1'b0, 1'b1, 8'h00); step(1'b0, 1'b0, 1'b0, 8'h00); end
    endtask

    task automatic set_entry(input logic [7:0] f0, input logic [7:0] f1);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, f0);
        step(1'b1, 1'b0, 1'b0, f1);
    endtask

    task automatic peek();
        @(posedge clk); #2;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_count"}, count_bcd, 0);
        check({tag, "_display"}, display_bcd, 0);
        check({tag, "_set_idx"}, set_idx, 0);
        check({tag, "_running"}, running, 0);
        check({tag, "_expired"}, expired, 0);
        check({tag, "_expired_p"}, expired_p, 0);
        check({tag, "_flash"}, flash, 0);
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t         e;
        logic [W-1:0] disp;
        forever begin
            @(posedge clk); #1;
            if (sb.size() != 0) begin
                e    = sb.pop_front();
                disp = e.count;
                if (e.in_set) disp[8*e.idx +: 8] = sw;
                check("count_bcd", count_bcd, e.count);
                check("display_bcd", display_bcd, disp);
                if (e.in_set) check("set_idx", set_idx, e.idx);
                check("running", running, e.run);
                check("expired", expired, e.exp);
                check("expired_p", expired_p, e.exp_p);
                check("flash", flash, e.fl);
            end
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin : driver
        int wait_cycles;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset_held");
        reset = 1'b1;
        idle(1);
        peek();
        check_all_zero("reset_released");

        // 01:05 counts down through 65 ticks to expiry, then flashes.
        set_entry(8'h05, 8'h01);
        peek();
        check("load_0105", count_bcd, 16'h0105);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        tick_n(65);
        peek();
`ifndef AUTO_RELOAD_EN
        check("expired_after_65", expired, 1'b1);
        check("count_after_65", count_bcd, 16'h0000);
`endif
        idle(3 * FLASH_DIV + 2);
        step(1'b0, 1'b1, 1'b0, 8'h00);

        // Clamping of non-BCD and over-range entries.
        set_entry(8'h7A, 8'hC3);
        peek();
        check("clamp_9359", count_bcd, 16'h9359);

        // Pause holds the count; resume continues.
        set_entry(8'h10, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        tick_n(3);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        tick_n(5);
        peek();
        check("pause_hold", count_bcd, 16'h0007);
        check("pause_running", running, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        tick_n(2);
        peek();
        check("resume_dec", count_bcd, 16'h0005);

        // Pause wins over a same-cycle tick.
        step(1'b0, 1'b1, 1'b1, 8'h00);
        peek();
        check("pause_vs_tick_count", count_bcd, 16'h0005);
        check("pause_vs_tick_running", running, 1'b0);

        // Start with an all-zero count is ignored.
        set_entry(8'h00, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        peek();
        check("start_zero_running", running, 1'b0);

        // Abort SET after field 0 keeps field 1.
        set_entry(8'h00, 8'h07);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h42);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        peek();
        check("abort_keep", count_bcd, 16'h0742);

        // Asynchronous reset in the middle of RUN.
        step(1'b0, 1'b1, 1'b0, 8'h00);
        tick_n(3);
        @(posedge clk); #3;
        set_p = 1'b0; start_stop_p = 1'b0; tick = 1'b0; sw = 8'h00;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(negedge clk); @(negedge clk);
        reset = 1'b1;

`ifdef AUTO_RELOAD_EN
        set_entry(8'h02, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        tick_n(5);
        peek();
        check("reload_running", running, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'h00);
`endif

        // Randomised traffic against the model.
        repeat (1500) begin
            step($urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 2) == 0, 8'($urandom));
        end
        idle(4);

        wait_cycles = 0;
        while (sb.size() != 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
